// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin synchronizers, glitch filters, frame FSM with watchdog,
// and a set-2 decoder that folds E0/F0 prefixes into one key event.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_break,
  output logic       frame_err,
  output logic       busy
);
  // state  | meaning
  // IDLE   | waiting for a start bit (data 0 on a clock fall)
  // DATA   | shifting in 8 data bits, LSB first
  // PARITY | capturing the odd-parity bit
  // STOP   | checking stop bit and parity, then back to IDLE
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT_CYCLES - 1);

  // bit 0 = ps2_clk, bit 1 = ps2_data
  logic [1:0]     s1_q, s2_q, filt_q, filt_d;
  logic [FCW-1:0] fcnt_q [2];
  logic [FCW-1:0] fcnt_d [2];
  logic           clk_prev_q;
  logic           strobe, din;

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           byte_valid_q, byte_valid_d;
  logic [7:0]     byte_data_q, byte_data_d;
  logic           frame_err_q, frame_err_d;

  logic           ext_q, ext_d, brk_q, brk_d;
  logic           key_valid_q, key_valid_d;
  logic [7:0]     key_code_q, key_code_d;
  logic           key_ext_q, key_ext_d, key_brk_q, key_brk_d;

  // Filtered value moves only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = fcnt_q[i];
      if (s2_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
        filt_d[i] = s2_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + FCW'(1);
      end
    end
  end

  assign strobe = clk_prev_q & ~filt_q[0];
  assign din    = filt_q[1];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    wd_d         = wd_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        wd_d = WD_LOAD;
        if (strobe && !din) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: if (strobe) begin
        shift_d   = {din, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (strobe) begin
        par_d   = din;
        state_d = STOP;
      end
      STOP: if (strobe) begin
        state_d = IDLE;
        if (din && ((^shift_q) ^ par_q)) begin
          byte_valid_d = 1'b1;
          byte_data_d  = shift_q;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A strobe in the same cycle as terminal count wins over the timeout.
    if (state_q != IDLE) begin
      if (strobe) begin
        wd_d = WD_LOAD;
      end else if (wd_q == '0) begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
      end else begin
        wd_d = wd_q - WDW'(1);
      end
    end
  end

  always_comb begin
    ext_d       = ext_q;
    brk_d       = brk_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_brk_d   = key_brk_q;
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid_q) begin
      case (byte_data_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        default: begin
          key_valid_d = 1'b1;
          key_code_d  = byte_data_q;
          key_ext_d   = ext_q;
          key_brk_d   = brk_q;
          ext_d       = 1'b0;
          brk_d       = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      s1_q         <= 2'b11;
      s2_q         <= 2'b11;
      filt_q       <= 2'b11;
      fcnt_q[0]    <= '0;
      fcnt_q[1]    <= '0;
      clk_prev_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      wd_q         <= WD_LOAD;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      key_brk_q    <= 1'b0;
    end else begin
      s1_q         <= {ps2_data, ps2_clk};
      s2_q         <= s1_q;
      filt_q       <= filt_d;
      fcnt_q[0]    <= fcnt_d[0];
      fcnt_q[1]    <= fcnt_d[1];
      clk_prev_q   <= filt_q[0];
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      wd_q         <= wd_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_brk_q    <= key_brk_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign frame_err    = frame_err_q;
  assign busy         = (state_q != IDLE);
  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign key_extended = key_ext_q;
  assign key_break    = key_brk_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx; PS/2 bit period scaled to 80 system clocks
// with a 500-cycle watchdog so the whole run stays short.
module tb_ps2_keyboard_rx;
  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       byte_valid, key_valid, key_extended, key_break, frame_err, busy;
  logic [7:0] byte_data, key_code;

  int checks = 0, failures = 0;
  int cyc = 0, fall_cyc = 0, busy_lat = -1;
  int nbv = 0, nkv = 0, nerr = 0, nbusy = 0, nlat = 0, nboth = 0;
  logic [7:0] last_byte = '0;
  logic bv_prev = 1'b0, busy_prev = 1'b0;

  ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(500)) dut (
    .clock(clock), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .key_valid(key_valid),
    .key_code(key_code), .key_extended(key_extended), .key_break(key_break),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (byte_valid) begin nbv++; last_byte = byte_data; end
    if (key_valid) nkv++;
    if (key_valid && !bv_prev) nlat++;
    if (frame_err) nerr++;
    if (frame_err && byte_valid) nboth++;
    if (busy) nbusy++;
    if (busy && !busy_prev) busy_lat = cyc - fall_cyc;
    bv_prev   = byte_valid;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clr();
    nbv = 0; nkv = 0; nerr = 0; nbusy = 0; nlat = 0; nboth = 0;
  endtask

  function automatic logic [10:0] frm(input logic [7:0] d, input logic bad_par);
    return {1'b1, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  // Data changes mid-high, then a 40-cycle low phase and the rest of the high phase.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cyc(20);
      ps2_clk = 1'b0;
      if (i == 0) fall_cyc = cyc;
      wait_cyc(40);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic bad_par);
    send_bits(frm(d, bad_par), 11);
    wait_cyc(60);
  endtask

  initial begin
    wait_cyc(5);
    chk("reset_outs", {23'd0, byte_valid, key_valid, key_extended, key_break, frame_err, busy, 2'b0},
        32'd0);
    chk("reset_codes", {16'd0, byte_data, key_code}, 32'd0);
    rst = 1'b0;
    wait_cyc(20);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 1: plain make code
    clr();
    send(8'h1C, 1'b0);
    chk("t1_start_latency", busy_lat, 32'd11);
    chk("t1_nbv", nbv, 1);
    chk("t1_byte", {24'd0, last_byte}, 32'h1C);
    chk("t1_nkv", nkv, 1);
    chk("t1_key", {22'd0, key_code, key_extended, key_break}, {22'd0, 8'h1C, 2'b00});

    // 2: break code
    clr();
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    chk("t2_nbv", nbv, 2);
    chk("t2_nkv", nkv, 1);
    chk("t2_key", {22'd0, key_code, key_extended, key_break}, {22'd0, 8'h1C, 2'b01});

    // 3: extended break, then BAT and ack swallowed
    clr();
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0);
    chk("t3_nkv", nkv, 1);
    chk("t3_key", {22'd0, key_code, key_extended, key_break}, {22'd0, 8'h75, 2'b11});
    clr();
    send(8'hAA, 1'b0);
    send(8'hFA, 1'b0);
    chk("t3_ack_nbv", nbv, 2);
    chk("t3_ack_nkv", nkv, 0);

    // 4: parity error, and an error flushes a pending E0
    clr();
    send(8'h1C, 1'b1);
    chk("t4_nerr", nerr, 1);
    chk("t4_nbv", nbv, 0);
    chk("t4_byte_held", {24'd0, byte_data}, 32'hFA);
    clr();
    send(8'hE0, 1'b0);
    send(8'h1C, 1'b1);
    send(8'h1C, 1'b0);
    chk("t4_flush_nerr", nerr, 1);
    chk("t4_flush_nkv", nkv, 1);
    chk("t4_flush_key", {22'd0, key_code, key_extended, key_break}, {22'd0, 8'h1C, 2'b00});

    // 5: watchdog on a stalled frame
    clr();
    send_bits(frm(8'h00, 1'b0), 5);
    chk("t5_busy_mid", {31'd0, busy}, 1);
    wait_cyc(800);
    chk("t5_nerr", nerr, 1);
    chk("t5_nbv", nbv, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    clr();
    send(8'h32, 1'b0);
    chk("t5_after_nkv", nkv, 1);
    chk("t5_after_key", {22'd0, key_code, key_extended, key_break}, {22'd0, 8'h32, 2'b00});

    // 6: short clock glitch is filtered out
    clr();
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(40);
    chk("t6_glitch_busy", nbusy, 0);
    chk("t6_glitch_nerr", nerr, 0);

    // 6b: reset mid-frame
    clr();
    send_bits(frm(8'h5A, 1'b0), 4);
    chk("t6_mid_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    wait_cyc(1);
    chk("t6_rst_outs", {23'd0, byte_valid, key_valid, key_extended, key_break, frame_err, busy, 2'b0},
        32'd0);
    chk("t6_rst_codes", {16'd0, byte_data, key_code}, 32'd0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(20);
    chk("t6_rst_nerr", nerr, 0);
    clr();
    send(8'h1C, 1'b0);
    chk("t6_post_nkv", nkv, 1);
    chk("t6_post_key", {22'd0, key_code, key_extended, key_break}, {22'd0, 8'h1C, 2'b00});

    chk("key_follows_byte", nlat, 0);
    chk("bv_err_exclusive", nboth, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
